// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rf_wb_arbiter_pkg                                            |
// | Purpose  : Shared types and constants for the register-file writeback  |
// |            arbiter: FSM state enum, the x0 address constant and the     |
// |            default data/address widths.                                 |
// | Ports    : none (package)                                              |
// | Revision : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
package rf_wb_arbiter_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } arb_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int NREQ_DEF = 3;
   localparam int XLEN_DEF = 32;
   localparam int AW_DEF   = 5;

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rf_wb_arbiter_if                                             |
// | Purpose  : Bundles the requester handshake, quiesce handshake and RF    |
// |            write-port signals of the writeback arbiter.                 |
// | Signals  : req_valid/req_ready  per-requester valid/ready (NREQ)         |
// |            req_addr/req_data    packed per-requester addr/data          |
// |            quiesce_req/_ack     drain/halt handshake                    |
// |            rf_wr_en/addr/data   register-file write port                |
// | Modports : master (requesters + debug + RF), slave (arbiter)           |
// | Revision : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
interface rf_wb_arbiter_if
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*XLEN-1:0] req_data;
   logic                 quiesce_req;
   logic                 quiesce_ack;
   logic                 rf_wr_en;
   logic [AW-1:0]        rf_addr;
   logic [XLEN-1:0]      rf_data;

   modport master (
      output req_valid, req_addr, req_data, quiesce_req,
      input  req_ready, quiesce_ack, rf_wr_en, rf_addr, rf_data
   );

   modport slave (
      input  req_valid, req_addr, req_data, quiesce_req,
      output req_ready, quiesce_ack, rf_wr_en, rf_addr, rf_data
   );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                   |
// | Purpose  : Combinational round-robin pick: first set request at or     |
// |            above the pointer, wrapping modulo NREQ.                     |
// | Ports    : req_i  request vector       ptr_i  search start index        |
// |            en_i   global grant enable  gnt_o  one-hot grant             |
// |            idx_o  binary index of the grant (0 when none)              |
// | Revision : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module rr_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int  NREQ = NREQ_DEF,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o
);

   // One spare bit so ptr+k cannot overflow before the modulo fold.
   logic [PW:0] cand;
   logic        found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_i} + (PW+1)'(k);
         if (cand >= (PW+1)'(NREQ)) begin
            cand = cand - (PW+1)'(NREQ);
         end
         if (en_i && !found && req_i[cand[PW-1:0]]) begin
            found                = 1'b1;
            gnt_o[cand[PW-1:0]]  = 1'b1;
            idx_o                = cand[PW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : rf_wb_arbiter                                                |
// | Purpose  : Shares the single RF write port among NREQ writeback        |
// |            sources with round-robin valid/ready arbitration, a one-    |
// |            cycle registered output stage and a quiesce (drain/halt)    |
// |            handshake for debug.                                         |
// | Ports    : clk        clock, rising edge                               |
// |            rst_n      asynchronous reset, active-low                   |
// |            bus_if     rf_wb_arbiter_if.slave (requesters, quiesce, RF) |
// |            stall_cnt  per-requester saturating stall counters          |
// |                       (present only with RF_ARB_STATS_EN)              |
// | Options  : `define RF_ARB_STATS_EN adds the CNTW parameter and the     |
// |            stall_cnt port/counters.                                     |
// | Revision : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int XLEN = XLEN_DEF,
   parameter int AW   = AW_DEF
`ifdef RF_ARB_STATS_EN
  ,parameter int CNTW = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   rf_wb_arbiter_if.slave   bus_if
`ifdef RF_ARB_STATS_EN
  ,output logic [NREQ*CNTW-1:0] stall_cnt
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e      state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic            ack_q, ack_d;

   logic            grant_en;
   logic [NREQ-1:0] gnt;
   logic [PW-1:0]   gnt_idx;
   logic            hs;
   logic [AW-1:0]   sel_addr;
   logic [XLEN-1:0] sel_data;

   // ---------------- arbitration ----------------
   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req_i (bus_if.req_valid),
      .ptr_i (ptr_q),
      .en_i  (grant_en),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   // Grants only go to valid requesters, so any grant is a handshake.
   assign hs       = |gnt;
   assign sel_addr = bus_if.req_addr[int'(gnt_idx)*AW +: AW];
   assign sel_data = bus_if.req_data[int'(gnt_idx)*XLEN +: XLEN];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus_if.quiesce_req) state_d = DRAIN;
         DRAIN: begin
            if (!bus_if.quiesce_req)  state_d = RUN;
            else if (!wr_en_q)        state_d = HALTED;
         end
         HALTED:  if (!bus_if.quiesce_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Grants are blocked in the very cycle quiesce_req rises, and held low
   // while reset is asserted so req_ready reads 0 during reset.
   always_comb begin
      grant_en = rst_n && (state_q == RUN) && !bus_if.quiesce_req;
      ack_d    = (state_d == HALTED);
   end

   // ---------------- pointer ----------------
   if (NREQ > 1) begin : g_ptr_rr
      always_comb begin
         ptr_d = ptr_q;
         if (hs) begin
            ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end else begin : g_ptr_const
      assign ptr_d = '0;
   end

   // ---------------- output stage ----------------
   // Writes to x0 complete the handshake but never reach the RF; addr/data
   // keep their last values whenever no write is issued.
   always_comb begin
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (hs && (sel_addr != AW'(REG_ZERO))) begin
         wr_en_d = 1'b1;
         addr_d  = sel_addr;
         data_d  = sel_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign bus_if.req_ready   = gnt;
   assign bus_if.rf_wr_en    = wr_en_q;
   assign bus_if.rf_addr     = addr_q;
   assign bus_if.rf_data     = data_q;
   assign bus_if.quiesce_ack = ack_q;

   // ---------------- stall statistics ----------------
`ifdef RF_ARB_STATS_EN
   for (genvar i = 0; i < NREQ; i++) begin : g_stall
      logic [CNTW-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else if (bus_if.req_valid[i] && !gnt[i] && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
      assign stall_cnt[i*CNTW +: CNTW] = cnt_q;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module   : tb_rf_wb_arbiter                                             |
// | Purpose  : Self-checking bench for rf_wb_arbiter: directed scenarios   |
// |            with literal expectations plus a randomized run, all        |
// |            compared every cycle against a behavioural model.           |
// | Revision : 1.0  initial release                                        |
// +-------------------------------------------------------------------------+
module tb_rf_wb_arbiter;

   localparam int NREQ = 3;
   localparam int XLEN = 32;
   localparam int AW   = 5;
`ifdef RF_ARB_STATS_EN
   localparam int CNTW = 2;
   logic [NREQ*CNTW-1:0] stall_cnt;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

   rf_wb_arbiter #(
      .NREQ(NREQ), .XLEN(XLEN), .AW(AW)
`ifdef RF_ARB_STATS_EN
     ,.CNTW(CNTW)
`endif
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus)
`ifdef RF_ARB_STATS_EN
     ,.stall_cnt(stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: mode 0=running, 1=draining, 2=halted
   int              m_ptr;
   int              m_mode;
   bit              m_wr;
   logic [AW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;
   bit              m_ack;
   int              m_stall[NREQ];
   logic [NREQ-1:0] m_last_g;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_mode = 0; m_wr = 0; m_addr = '0; m_data = '0; m_ack = 0;
      m_last_g = '0;
      for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", bus.rf_wr_en, 0);
      chk("rst_addr", bus.rf_addr, 0);
      chk("rst_data", bus.rf_data, 0);
      chk("rst_ack", bus.quiesce_ack, 0);
      chk("rst_ready", bus.req_ready, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One cycle: compare at negedge, advance the model, return at posedge+1.
   task automatic tick();
      logic [NREQ-1:0] g;
      int gi, nm, j;
      logic [AW-1:0] ga;
      @(negedge clk);
      g = '0; gi = 0;
      if (m_mode == 0 && !bus.quiesce_req) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g == '0 && bus.req_valid[j]) begin
               g[j] = 1'b1;
               gi = j;
            end
         end
      end
      chk("ready", bus.req_ready, g);
      chk("wr_en", bus.rf_wr_en, m_wr);
      chk("rf_addr", bus.rf_addr, m_addr);
      chk("rf_data", bus.rf_data, m_data);
      chk("ack", bus.quiesce_ack, m_ack);
`ifdef RF_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
         chk("stall_cnt", stall_cnt[i*CNTW +: CNTW], m_stall[i]);
      for (int i = 0; i < NREQ; i++)
         if (bus.req_valid[i] && !g[i] && m_stall[i] < (1 << CNTW) - 1) m_stall[i]++;
`endif
      nm = m_mode;
      if (m_mode == 0 && bus.quiesce_req) nm = 1;
      else if (m_mode == 1 && !bus.quiesce_req) nm = 0;
      else if (m_mode == 1 && !m_wr) nm = 2;
      else if (m_mode == 2 && !bus.quiesce_req) nm = 0;
      m_mode = nm;
      m_ack = (nm == 2);
      m_wr = 0;
      if (g != '0) begin
         m_ptr = (gi + 1) % NREQ;
         ga = bus.req_addr[gi*AW +: AW];
         if (ga != 0) begin
            m_wr = 1;
            m_addr = ga;
            m_data = bus.req_data[gi*XLEN +: XLEN];
         end
      end
      m_last_g = g;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      bus.req_valid[i] = 1'b1;
      bus.req_addr[i*AW +: AW] = a;
      bus.req_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic rand_drive();
      for (int i = 0; i < NREQ; i++) begin
         if (!bus.req_valid[i] || m_last_g[i]) begin
            if ($urandom_range(0, 2) == 0)
               set_req(i, ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom), $urandom);
            else
               bus.req_valid[i] = 1'b0;
         end
      end
      if ($urandom_range(0, 29) == 0) bus.quiesce_req = !bus.quiesce_req;
   endtask

   initial begin
      bus.req_valid = '0;
      bus.req_addr = '0;
      bus.req_data = '0;
      bus.quiesce_req = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // 1: single write, one-cycle latency
      set_req(0, 5'd5, 32'hDEADBEEF);
      #1 chk("t1_ready", bus.req_ready, 3'b001);
      tick();
      bus.req_valid = '0;
      #1;
      chk("t1_wr_en", bus.rf_wr_en, 1);
      chk("t1_addr", bus.rf_addr, 5);
      chk("t1_data", bus.rf_data, 32'hDEADBEEF);
      tick();

      // 2: round robin from pointer 0
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), XLEN'(32'hA0 + i));
      for (int c = 0; c < 6; c++) begin
         #1 chk("t2_ready", bus.req_ready, 3'b001 << (c % 3));
         if (c > 0) chk("t2_wr_en", bus.rf_wr_en, 1);
         tick();
      end
      bus.req_valid = '0;
      tick();

      // 3: x0 write is released, not written, pointer moves to 2
      set_req(1, 5'd0, 32'h1234);
      #1 chk("t3_ready", bus.req_ready, 3'b010);
      tick();
      bus.req_valid = '0;
      #1;
      chk("t3_wr_en", bus.rf_wr_en, 0);
      chk("t3_addr_hold", bus.rf_addr, 3);
      tick();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), XLEN'(32'hB0 + i));
      #1 chk("t3_ptr", bus.req_ready, 3'b100);
      tick();
      bus.req_valid = '0;
      tick();

      // 4: quiesce right after an accepted write
      set_req(0, 5'd7, 32'h77);
      #1 chk("t4_ready_n", bus.req_ready, 3'b001);
      tick();
      set_req(0, 5'd8, 32'h88);
      bus.quiesce_req = 1'b1;
      #1;
      chk("t4_ready_n1", bus.req_ready, 0);
      chk("t4_wr_n1", bus.rf_wr_en, 1);
      chk("t4_addr_n1", bus.rf_addr, 7);
      tick();
      #1;
      chk("t4_ready_n2", bus.req_ready, 0);
      chk("t4_wr_n2", bus.rf_wr_en, 0);
      chk("t4_ack_n2", bus.quiesce_ack, 0);
      tick();
      #1 chk("t4_ack_n3", bus.quiesce_ack, 1);
      tick();
      bus.quiesce_req = 1'b0;
      #1 chk("t4_ready_halted", bus.req_ready, 0);
      tick();
      #1;
      chk("t4_ready_resume", bus.req_ready, 3'b001);
      chk("t4_ack_clear", bus.quiesce_ack, 0);
      tick();
      bus.req_valid = '0;
      tick();

      // 5: reset the cycle after a handshake
      set_req(0, 5'd9, 32'h99);
      tick();
      bus.req_valid = '0;
      #1 chk("t5_wr_before", bus.rf_wr_en, 1);
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), XLEN'(32'hC0 + i));
      #1 chk("t5_ptr0", bus.req_ready, 3'b001);
      tick();
      bus.req_valid = '0;
      tick();

`ifdef RF_ARB_STATS_EN
      // 6: stall counter saturation
      do_reset();
      bus.quiesce_req = 1'b1;
      set_req(2, 5'd4, 32'h44);
      repeat (6) tick();
      #1;
      chk("t6_sat", stall_cnt[2*CNTW +: CNTW], 3);
      chk("t6_idle", stall_cnt[0 +: CNTW], 0);
      bus.quiesce_req = 1'b0;
      repeat (3) tick();
      bus.req_valid = '0;
      tick();
`endif

      // randomized run
      for (int c = 0; c < 3000; c++) begin
         rand_drive();
         tick();
      end
      bus.req_valid = '0;
      bus.quiesce_req = 1'b0;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
